// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side and system-bus-side signals of the sprite DMA arbiter.
// master = the DMA/arbiter block, slave = the CPU core plus bus environment.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_d_out, cpu_we, bus_d_in,
    output cpu_rdy, bus_addr, bus_d_out, bus_we, dma_active
  );

  modport slave (
    output cpu_addr, cpu_d_out, cpu_we, bus_d_in,
    input  cpu_rdy, bus_addr, bus_d_out, bus_we, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA controller and CPU/system-bus arbiter.
// A CPU write to TRIG_ADDR latches a source page, halts the CPU and copies
// {page,8'h00}..{page,8'hFF} to DEST_ADDR, one READ/WRITE cycle pair per byte.
// Build option OAM_DMA_ALIGN_EN: adds a free-running parity flop and an ALIGN
// cycle so every READ lands on a parity==0 cycle (513 or 514 halt cycles);
// without it every transfer halts the CPU for exactly 513 cycles.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   page_q, page_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rdy_q;
  logic            active_q;

`ifdef OAM_DMA_ALIGN_EN
  logic            par_q;

  // Free-running cycle parity, independent of the transfer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= ~par_q;
  end
`endif

  // State, transfer registers and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      page_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rdy_q    <= (state_d == IDLE);
      active_q <= (state_d != IDLE);
    end
  end

  // Next-state logic: trigger detect, halt/align sequencing, byte counter
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_we && (bus.cpu_addr == TRIG_ADDR)) begin
          page_d  = bus.cpu_d_out;
          cnt_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = par_q ? READ : ALIGN;
`else
        state_d = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: state_d = READ;
`endif
      READ: begin
        data_d  = bus.bus_d_in;
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + DW'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: CPU passthrough unless the DMA owns the bus
  always_comb begin
    bus.bus_addr  = bus.cpu_addr;
    bus.bus_d_out = bus.cpu_d_out;
    bus.bus_we    = bus.cpu_we;
    case (state_q)
      HALT: bus.bus_we = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: bus.bus_we = 1'b0;
`endif
      READ: begin
        bus.bus_addr = AW'({page_q, cnt_q});
        bus.bus_we   = 1'b0;
      end
      WRITE: begin
        bus.bus_addr  = DEST_ADDR;
        bus.bus_d_out = data_q;
        bus.bus_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdy    = rdy_q;
  assign bus.dma_active = active_q;

endmodule
